// File: rtl/m_ext_ctrl.sv
// Sequencer between EX and the multicycle M-extension unit: launches the unit,
// stalls EX until it responds, short-circuits divide special cases and a one-entry result cache.
module m_ext_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_m,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        m_load,
    output logic [31:0] m_a,
    output logic [31:0] m_b,
    output logic [2:0]  m_funct3,
    input  logic        m_resp,
    input  logic [31:0] m_out,
    output logic        m_stall,
    output logic [31:0] m_result,
    output logic        m_result_valid
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t          state;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] tag_a;
    logic [XLEN-1:0] tag_b;
    logic [2:0]      tag_f3;
    logic            cache_vld;

    logic            issue;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic            hit;
    logic [XLEN-1:0] special_res;

    // Issue decode, divide special cases and cache lookup against the live EX operands
    always_comb begin
        issue    = ex_valid & ex_is_m & ~flush;
        div_zero = ex_funct3[2] & (ex_b == '0);
        div_ovf  = ex_funct3[2] & ~ex_funct3[0] & (ex_a == INT_MIN) & (ex_b == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = ex_funct3[1] ? ex_a : '1;
        end else begin
            special_res = ex_funct3[1] ? '0 : INT_MIN;
        end
        hit = cache_vld & (ex_a == tag_a) & (ex_b == tag_b) & (ex_funct3 == tag_f3);
    end

    // Result/stall are combinational so specials and hits retire with zero stall
    always_comb begin
        m_stall        = 1'b0;
        m_result_valid = 1'b0;
        m_result       = '0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        if (special) begin
                            m_result_valid = 1'b1;
                            m_result       = special_res;
                        end else if (hit) begin
                            m_result_valid = 1'b1;
                            m_result       = res_q;
                        end else begin
                            m_stall = 1'b1;
                        end
                    end
                end
                S_LAUNCH, S_WAIT: m_stall = 1'b1;
                S_DONE: begin
                    m_result_valid = 1'b1;
                    m_result       = res_q;
                end
                S_DRAIN: m_stall = issue;
                default: m_stall = 1'b0;
            endcase
        end
    end

    // Sequencer, operand latch and result cache; res_q doubles as the cached data
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            m_load    <= 1'b0;
            m_a       <= '0;
            m_b       <= '0;
            m_funct3  <= '0;
            res_q     <= '0;
            tag_a     <= '0;
            tag_b     <= '0;
            tag_f3    <= '0;
            cache_vld <= 1'b0;
        end else begin
            m_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue && !special && !hit) begin
                        m_a      <= ex_a;
                        m_b      <= ex_b;
                        m_funct3 <= ex_funct3;
                        m_load   <= 1'b1;
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: state <= flush ? S_DRAIN : S_WAIT;
                S_WAIT: begin
                    // A response in the flush cycle means the unit is already idle
                    if (flush) begin
                        state <= m_resp ? S_IDLE : S_DRAIN;
                    end else if (m_resp) begin
                        res_q     <= m_out;
                        tag_a     <= m_a;
                        tag_b     <= m_b;
                        tag_f3    <= m_funct3;
                        cache_vld <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || !ex_hold) begin
                        state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (m_resp) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_ext_ctrl.sv
// Randomized self-checking bench for m_ext_ctrl with a behavioural M unit and
// an arithmetic reference model of the instruction results and cache.
module tb_m_ext_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_m, ex_hold, flush;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_a, ex_b;
    logic        m_load;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_funct3;
    logic        m_resp;
    logic [31:0] m_out;
    logic        m_stall;
    logic [31:0] m_result;
    logic        m_result_valid;

    int n_vec = 0;
    int n_err = 0;

    // reference cache model
    logic        c_vld = 1'b0;
    logic [31:0] c_a = '0, c_b = '0;
    logic [2:0]  c_f3 = '0;

    // behavioural M unit
    int          resp_delay = 1;
    logic        u_pend;
    int          u_cnt;
    logic [31:0] u_res;

    m_ext_ctrl dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_m(ex_is_m),
        .ex_funct3(ex_funct3), .ex_a(ex_a), .ex_b(ex_b), .ex_hold(ex_hold),
        .flush(flush), .m_load(m_load), .m_a(m_a), .m_b(m_b), .m_funct3(m_funct3),
        .m_resp(m_resp), .m_out(m_out), .m_stall(m_stall), .m_result(m_result),
        .m_result_valid(m_result_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Unit responds resp_delay cycles after the cycle in which m_load is high
    always @(posedge clk) begin
        if (rst) begin
            u_pend <= 1'b0;
            u_cnt  <= 0;
            m_resp <= 1'b0;
            m_out  <= '0;
        end else begin
            m_resp <= 1'b0;
            if (u_pend) begin
                if (u_cnt == 1) begin
                    m_resp <= 1'b1;
                    m_out  <= u_res;
                    u_pend <= 1'b0;
                end else begin
                    u_cnt <= u_cnt - 1;
                end
            end
            if (m_load) begin
                if (resp_delay <= 1) begin
                    m_resp <= 1'b1;
                    m_out  <= ref_m(m_funct3, m_a, m_b);
                end else begin
                    u_pend <= 1'b1;
                    u_cnt  <= resp_delay - 1;
                    u_res  <= ref_m(m_funct3, m_a, m_b);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        ex_is_m  = 1'b0;
        flush    = 1'b0;
        ex_hold  = 1'b0;
    endtask

    // After a flush in cycle fc: optionally probe DRAIN stall, then wait out the unit
    task automatic drain(input int dly, input int fc, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        for (int c = fc + 1; c <= dly + 3; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == fc + 1 && dly >= 2) begin
                ex_valid = 1'b1; ex_is_m = 1'b1; ex_funct3 = f3; ex_a = a; ex_b = b;
                #1;
                check("drain_issue_stall", 32'(m_stall), 32'd1);
            end else begin
                #1;
                check("drain_stall", 32'(m_stall), 32'd0);
            end
            check("drain_valid", 32'(m_result_valid), 32'd0);
            check("drain_load", 32'(m_load), 32'd0);
        end
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int dly, input int hold, input int flush_at);
        logic [31:0] exp;
        logic        special, hit, done;
        int          cyc;
        exp     = ref_m(f3, a, b);
        special = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        hit     = !special && c_vld && c_a == a && c_b == b && c_f3 == f3;
        @(negedge clk);
        resp_delay = dly;
        ex_valid = 1'b1; ex_is_m = 1'b1; ex_funct3 = f3; ex_a = a; ex_b = b;
        flush = 1'b0; ex_hold = 1'b0;
        #1;
        if (special || hit) begin
            check(special ? "spec_valid" : "hit_valid", 32'(m_result_valid), 32'd1);
            check(special ? "spec_result" : "hit_result", m_result, exp);
            check("imm_stall", 32'(m_stall), 32'd0);
            @(negedge clk);
            idle_inputs();
            #1;
            check("imm_no_load", 32'(m_load), 32'd0);
            check("imm_idle_valid", 32'(m_result_valid), 32'd0);
            return;
        end
        check("miss_stall", 32'(m_stall), 32'd1);
        check("miss_valid", 32'(m_result_valid), 32'd0);
        @(negedge clk);
        if (flush_at == 1) flush = 1'b1;
        #1;
        check("load_pulse", 32'(m_load), 32'd1);
        check("op_a", m_a, a);
        check("op_b", m_b, b);
        check("op_f3", 32'(m_funct3), 32'(f3));
        check("launch_stall", 32'(m_stall), 32'd1);
        if (flush_at == 1) begin
            drain(dly, 1, f3, a, b);
            return;
        end
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            flush = (flush_at == 2 && cyc == 2);
            if (cyc == dly + 2) ex_hold = (hold > 0);
            #1;
            check("single_load", 32'(m_load), 32'd0);
            if (flush) begin
                drain(dly, 2, f3, a, b);
                return;
            end
            if (m_result_valid) done = 1'b1;
            else check("wait_stall", 32'(m_stall), 32'd1);
        end
        check("latency", 32'(cyc), 32'(dly + 2));
        check("result", m_result, exp);
        check("done_stall", 32'(m_stall), 32'd0);
        c_vld = 1'b1; c_a = a; c_b = b; c_f3 = f3;
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            ex_hold = (h < hold);
            #1;
            check("hold_valid", 32'(m_result_valid), 32'd1);
            check("hold_result", m_result, exp);
            check("hold_no_load", 32'(m_load), 32'd0);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("after_done_valid", 32'(m_result_valid), 32'd0);
        check("after_done_load", 32'(m_load), 32'd0);
        check("after_done_stall", 32'(m_stall), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load"}, 32'(m_load), 32'd0);
        check({tag, "_stall"}, 32'(m_stall), 32'd0);
        check({tag, "_valid"}, 32'(m_result_valid), 32'd0);
        check({tag, "_result"}, m_result, 32'd0);
        check({tag, "_a"}, m_a, 32'd0);
        check({tag, "_b"}, m_b, 32'd0);
        check({tag, "_f3"}, 32'(m_funct3), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        int          fl;
        rst = 1'b1;
        ex_funct3 = '0; ex_a = '0; ex_b = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        do_op(3'd0, 32'd7, 32'd6, 3, 0, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0);
        do_op(3'd5, 32'd100, 32'd0, 1, 0, 0);
        do_op(3'd7, 32'd100, 32'd0, 1, 0, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0);
        do_op(3'd4, 32'd100, 32'd7, 4, 0, 2);
        do_op(3'd4, 32'd100, 32'd7, 2, 0, 0);
        do_op(3'd0, 32'd3, 32'd5, 1, 2, 0);
        do_op(3'd0, 32'd0, 32'd9, 2, 0, 1);
        do_op(3'd2, 32'hFFFF_FFF0, 32'd3, 1, 0, 2);

        // reset in the middle of WAIT
        @(negedge clk);
        resp_delay = 4;
        ex_valid = 1'b1; ex_is_m = 1'b1; ex_funct3 = 3'd5; ex_a = 32'd1000; ex_b = 32'd3;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        check_all_zero("midrst");
        rst = 1'b0;
        c_vld = 1'b0;
        do_op(3'd4, 32'd100, 32'd7, 1, 0, 0);

        // random phase: operand pool biased to specials, frequent repeats for cache hits
        rf3 = 3'd0; ra = 32'd1; rb = 32'd1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) >= 3) begin
                rf3 = 3'($urandom_range(0, 7));
                ra  = pick();
                rb  = pick();
            end
            fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_op(rf3, ra, rb, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), fl);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                #1;
                check("gap_stall", 32'(m_stall), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
